// File: rtl/str_stream_pkg.sv
// Shared types for the packed-string streamer.
//   char_t            : one ASCII character
//   NUL               : the padding character used in unused high bytes
//   streamer_state_e  : streamer control states
package str_stream_pkg;

    typedef logic [7:0] char_t;

    localparam char_t NUL = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } streamer_state_e;

endpackage

// File: rtl/str_lead_nul_count.sv
// Counts consecutive NUL bytes starting at the most significant byte of a
// packed string word. Purely combinational.
//   i_word : packed string, byte NBYTES-1 is the first character position
//   o_lead : number of leading NUL bytes (NBYTES for an all-zero word)
module str_lead_nul_count
    import str_stream_pkg::*;
#(
    parameter int unsigned NBYTES = 16,
    parameter int unsigned LENW   = $clog2(NBYTES + 1)
) (
    input  logic [8*NBYTES-1:0] i_word,
    output logic [LENW-1:0]     o_lead
);

    logic w_hit;

    // Priority scan from the MSB byte; stop counting at the first non-NUL.
    always_comb begin
        o_lead = '0;
        w_hit  = 1'b0;
        for (int i = NBYTES - 1; i >= 0; i--) begin
            if (!w_hit) begin
                if (i_word[i*8 +: 8] == NUL) begin
                    o_lead = o_lead + LENW'(1);
                end else begin
                    w_hit = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/str_char_streamer.sv
// Accepts one packed string word, strips its leading NUL bytes and streams
// the remaining characters MSB-first, one per cycle, over valid/ready.
//   clk, rst   : clock and asynchronous active-high reset
//   in_valid   : packed word offered        in_ready  : word can be accepted
//   in_data    : packed string word
//   out_valid  : out_char valid             out_ready : consumer takes char
//   out_char   : current character          out_last  : final char of word
//   out_len    : char count of current/most recent word
//   done       : one-cycle pulse when the word is fully consumed
module str_char_streamer
    import str_stream_pkg::*;
#(
    parameter int unsigned NBYTES = 16,
    parameter int unsigned LENW   = $clog2(NBYTES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_char,
    output logic                out_last,
    output logic [LENW-1:0]     out_len,
    output logic                done
);

    localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned WW   = 8 * NBYTES;

    streamer_state_e r_state, w_state_n;
    logic [WW-1:0]   r_word,  w_word_n;
    logic [IDXW-1:0] r_idx,   w_idx_n;
    logic [LENW-1:0] w_lead,  w_len_n;
    char_t           w_char_n;
    logic            w_last_n;
    logic            w_ready_n;
    logic            w_valid_n;
    logic            w_done_n;

    str_lead_nul_count #(
        .NBYTES (NBYTES),
        .LENW   (LENW)
    ) u_lead (
        .i_word (in_data),
        .o_lead (w_lead)
    );

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        w_state_n = r_state;
        w_word_n  = r_word;
        w_idx_n   = r_idx;
        w_len_n   = out_len;
        w_char_n  = out_char;
        w_last_n  = 1'b0;
        w_ready_n = 1'b0;
        w_valid_n = 1'b0;
        w_done_n  = 1'b0;

        case (r_state)
            IDLE: begin
                // in_data is only looked at when offered, so X on an idle bus stays out.
                if (in_valid && in_ready) begin
                    w_word_n = in_data;
                    w_len_n  = LENW'(NBYTES) - w_lead;
                    if (w_lead == LENW'(NBYTES)) begin
                        w_state_n = FIN;
                    end else begin
                        w_state_n = SEND;
                        w_idx_n   = IDXW'(NBYTES - 1) - IDXW'(w_lead);
                    end
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (r_idx == '0) begin
                        w_state_n = FIN;
                    end else begin
                        w_idx_n = r_idx - IDXW'(1);
                    end
                end
            end
            FIN: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        // Present the character the next state will show; hold it otherwise.
        if (w_state_n == SEND) begin
            w_char_n = w_word_n[{w_idx_n, 3'b000} +: 8];
            w_last_n = (w_idx_n == '0);
        end
        w_ready_n = (w_state_n == IDLE);
        w_valid_n = (w_state_n == SEND);
        w_done_n  = (w_state_n == FIN);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_word    <= '0;
            r_idx     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_char  <= NUL;
            out_last  <= 1'b0;
            out_len   <= '0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_word    <= w_word_n;
            r_idx     <= w_idx_n;
            in_ready  <= w_ready_n;
            out_valid <= w_valid_n;
            out_char  <= w_char_n;
            out_last  <= w_last_n;
            out_len   <= w_len_n;
            done      <= w_done_n;
        end
    end

endmodule

// File: tb/tb_str_char_streamer.sv
module tb_str_char_streamer;
    import str_stream_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready;
    logic [127:0] in_data;
    logic         out_valid, out_ready;
    logic [7:0]   out_char;
    logic         out_last;
    logic [4:0]   out_len;
    logic         done;

    logic         v3, r3;
    logic [23:0]  d3;
    logic         ov3, ol3, dn3;
    logic [7:0]   oc3;
    logic [1:0]   olen3;

    str_char_streamer #(.NBYTES(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_char(out_char), .out_last(out_last), .out_len(out_len), .done(done)
    );

    str_char_streamer #(.NBYTES(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3),
        .in_data(d3), .out_valid(ov3), .out_ready(1'b1),
        .out_char(oc3), .out_last(ol3), .out_len(olen3), .done(dn3)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] c;
        logic       last;
        int         len;
    } exp_t;

    exp_t q16[$];
    int   dq16[$];
    exp_t q3[$];
    int   dq3[$];
    exp_t e16, e3;
    bit   pend16 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got 0x%0h, nothing was expected", name, act);
    endtask

    task automatic exp16(input logic [7:0] c, input logic last, input int len);
        exp_t e;
        e.c = c; e.last = last; e.len = len;
        q16.push_back(e);
    endtask

    // Monitor for the 16-byte streamer: pops expectations on each handshake/done.
    always @(negedge clk) begin
        if (rst) begin
            pend16 = 1'b0;
        end else begin
            if (pend16) chk("done_latency", 32'(done), 32'd1);
            pend16 = out_valid && out_ready && out_last;
            if (out_valid && out_ready) begin
                if (q16.size() == 0) begin
                    fail("unexpected_char", 32'(out_char));
                end else begin
                    e16 = q16.pop_front();
                    chk("char", 32'(out_char), 32'(e16.c));
                    chk("last", 32'(out_last), 32'(e16.last));
                    chk("len",  32'(out_len),  32'(e16.len));
                end
            end
            if (done) begin
                if (dq16.size() == 0) fail("unexpected_done", 32'(out_len));
                else chk("done_len", 32'(out_len), 32'(dq16.pop_front()));
            end
        end
    end

    // Monitor for the 3-byte streamer.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov3) begin
                if (q3.size() == 0) begin
                    fail("n3_unexpected_char", 32'(oc3));
                end else begin
                    e3 = q3.pop_front();
                    chk("n3_char", 32'(oc3),   32'(e3.c));
                    chk("n3_last", 32'(ol3),   32'(e3.last));
                    chk("n3_len",  32'(olen3), 32'(e3.len));
                end
            end
            if (dn3) begin
                if (dq3.size() == 0) fail("n3_unexpected_done", 32'(olen3));
                else chk("n3_done_len", 32'(olen3), 32'(dq3.pop_front()));
            end
        end
    end

    // Offer a word, wait for acceptance, then check the cycle after accept.
    task automatic send16(input logic [127:0] d, input logic expv);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) fail("accept_timeout", 32'(n));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 'x;
        chk("accept_valid", 32'(out_valid), 32'(expv));
        chk("accept_done",  32'(done),      32'(!expv));
    endtask

    task automatic wait_done16();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        if (!done) begin
            fail("done_timeout", 32'(n));
        end else begin
            @(negedge clk);
            chk("ready_after_done", 32'(in_ready), 32'd1);
            chk("done_one_cycle",   32'(done),     32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got 0x0 expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_data = 'x; out_ready = 1'b1;
        v3 = 1'b0; d3 = 'x;

        #12;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_char",  32'(out_char),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_len",   32'(out_len),   32'd0);
        chk("rst_done",      32'(done),      32'd0);
        @(negedge clk);
        rst = 1'b0;

        // "FOO"
        exp16(8'h46, 1'b0, 3); exp16(8'h4F, 1'b0, 3); exp16(8'h4F, 1'b1, 3);
        dq16.push_back(3);
        send16(128'h464F4F, 1'b1);
        wait_done16();

        // All-zero word
        dq16.push_back(0);
        send16(128'h0, 1'b0);
        wait_done16();

        // Full 16 characters "ABCDEFGHIJKLMNOP"
        for (int k = 0; k < 16; k++) exp16(8'(8'h41 + k), k == 15, 16);
        dq16.push_back(16);
        send16(128'h4142434445464748494A4B4C4D4E4F50, 1'b1);
        wait_done16();

        // Embedded and trailing NULs
        exp16(8'h41, 1'b0, 4); exp16(8'h00, 1'b0, 4);
        exp16(8'h42, 1'b0, 4); exp16(8'h00, 1'b1, 4);
        dq16.push_back(4);
        send16(128'h41004200, 1'b1);
        wait_done16();

        // Backpressure on the second character of "FOO"
        exp16(8'h46, 1'b0, 3); exp16(8'h4F, 1'b0, 3); exp16(8'h4F, 1'b1, 3);
        dq16.push_back(3);
        send16(128'h464F4F, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_char",  32'(out_char),  32'h4F);
        end
        out_ready = 1'b1;
        wait_done16();

        // Reset after the first handshake of "FOO"
        exp16(8'h46, 1'b0, 3); exp16(8'h4F, 1'b0, 3); exp16(8'h4F, 1'b1, 3);
        dq16.push_back(3);
        send16(128'h464F4F, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready),  32'd1);
        chk("midrst_done",  32'(done),      32'd0);
        chk("midrst_len",   32'(out_len),   32'd0);
        q16.delete();
        dq16.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // "HI" after reset
        exp16(8'h48, 1'b0, 2); exp16(8'h49, 1'b1, 2);
        dq16.push_back(2);
        send16(128'h4849, 1'b1);
        wait_done16();

        // NBYTES=3 instance with "FOO"
        e3.c = 8'h46; e3.last = 1'b0; e3.len = 3; q3.push_back(e3);
        e3.c = 8'h4F; e3.last = 1'b0; e3.len = 3; q3.push_back(e3);
        e3.c = 8'h4F; e3.last = 1'b1; e3.len = 3; q3.push_back(e3);
        dq3.push_back(3);
        @(posedge clk); #1;
        v3 = 1'b1;
        d3 = 24'h464F4F;
        n = 0;
        while (!r3 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        v3 = 1'b0;
        d3 = 'x;
        chk("n3_accept_valid", 32'(ov3), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dn3 && n < 50);
        if (!dn3) fail("n3_done_timeout", 32'(n));
        repeat (2) @(negedge clk);
        chk("q16_drained", 32'(q16.size() + dq16.size()), 32'd0);
        chk("q3_drained",  32'(q3.size() + dq3.size()),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
